// File: rtl/controle_pc.sv
// Program counter and call/return sequencer driving the return-address stack.
// One cycle per instruction, RET takes two (pop, then load top-of-stack); stall freezes RUN only.
module controle_pc #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 128
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [2:0]                     op,
  input  logic                           cond,
  input  logic [ADDR_W-1:0]              alvo,
  output logic [ADDR_W-1:0]              pc,
  output logic                           pc_valid,
  output logic                           stk_push,
  output logic                           stk_pop,
  output logic [ADDR_W-1:0]              stk_dado,
  input  logic [ADDR_W-1:0]              stk_topo,
  output logic [$clog2(DEPTH+1)-1:0]     nivel,
  output logic                           erro_ovf,
  output logic                           erro_unf
);
  localparam int NIV_W = $clog2(DEPTH+1);
  localparam logic [NIV_W-1:0] NIV_MAX = NIV_W'(DEPTH);

  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  typedef enum logic {RUN, RET_WAIT} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_pc_valid;
  logic [NIV_W-1:0]    r_nivel;
  logic                r_ovf;
  logic                r_unf;

  logic [ADDR_W-1:0]   w_pc_inc;
  logic                w_exec;
  logic                w_full;
  logic                w_empty;

  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_exec   = (r_state == RUN) && !stall;
  assign w_full   = (r_nivel == NIV_MAX);
  assign w_empty  = (r_nivel == '0);

  // Strobes are decoded from current state so the stack acts on the same edge as the PC.
  assign stk_push = w_exec && (op == OP_CALL) && !w_full;
  assign stk_pop  = w_exec && (op == OP_RET) && !w_empty;
  assign stk_dado = w_pc_inc;

  assign pc       = r_pc;
  assign pc_valid = r_pc_valid;
  assign nivel    = r_nivel;
  assign erro_ovf = r_ovf;
  assign erro_unf = r_unf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_pc       <= '0;
      r_pc_valid <= 1'b1;
      r_nivel    <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (!stall) begin
            case (op)
              OP_JUMP:   r_pc <= alvo;
              OP_BRANCH: r_pc <= cond ? alvo : w_pc_inc;
              OP_CALL: begin
                if (w_full) begin
                  r_ovf <= 1'b1;
                  r_pc  <= w_pc_inc;
                end else begin
                  r_pc    <= alvo;
                  r_nivel <= r_nivel + NIV_W'(1);
                end
              end
              OP_RET: begin
                if (w_empty) begin
                  r_unf <= 1'b1;
                  r_pc  <= w_pc_inc;
                end else begin
                  // pc holds until the popped return address arrives next cycle
                  r_nivel    <= r_nivel - NIV_W'(1);
                  r_state    <= RET_WAIT;
                  r_pc_valid <= 1'b0;
                end
              end
              default:   r_pc <= w_pc_inc;
            endcase
          end
        end
        RET_WAIT: begin
          r_pc       <= stk_topo;
          r_state    <= RUN;
          r_pc_valid <= 1'b1;
        end
        default: r_state <= RUN;
      endcase
    end
  end
endmodule
